// File: rtl/smart_lift_pkg.sv
// smart_lift_pkg
// Shared types and constants for the DE2 lift controller: FSM state type,
// travel direction constants and the 7-segment digit table (bit0 = a,
// bit6 = g, active-high).
package smart_lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam logic [6:0] SEG7 [10] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

endpackage

// File: rtl/smart_lift_ctrl_if.sv
// smart_lift_ctrl_if
// Board-facing signal bundle of the lift controller.
//   SW     : floor-call switches, bit i = call to floor i (asynchronous)
//   floor  : current car floor (registered)
//   LED_G  : car stationary
//   LED_R  : car moving
//   HX0    : current-floor digit
//   HX1    : pending-call-count digit
// master = board/stimulus side, slave = controller side.
interface smart_lift_ctrl_if #(
    parameter int FLOORS = 9
);
    localparam int FW = $clog2(FLOORS);

    logic [FLOORS-1:0] SW;
    logic [FW-1:0]     floor;
    logic              LED_G;
    logic              LED_R;
    logic [6:0]        HX0;
    logic [6:0]        HX1;

    modport master (
        output SW,
        input  floor, LED_G, LED_R, HX0, HX1
    );

    modport slave (
        input  SW,
        output floor, LED_G, LED_R, HX0, HX1
    );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder
// 4-bit value to active-high 7-segment pattern (bit0 = a ... bit6 = g).
//   value : binary digit to show
//   seg   : segment drive; values above 9 blank the digit
module seg7_decoder
    import smart_lift_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (value == 4'(i)) begin
                seg = SEG7[i];
            end
        end
    end

endmodule

// File: rtl/smart_lift_ctrl.sv
// smart_lift_ctrl
// Elevator-car controller with a SCAN (collective) scheduler. Floor calls
// from the switches are synchronised, edge-detected and latched as pending
// requests; the car serves calls in its current direction before reversing.
// Floor travel and door dwell are timed with cycle counters.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : smart_lift_ctrl_if.slave (SW in; floor, LED_G, LED_R, HX0, HX1 out)
module smart_lift_ctrl
    import smart_lift_pkg::*;
#(
    parameter int FLOORS      = 9,
    parameter int FLOOR_TICKS = 50_000_000,
    parameter int DOOR_TICKS  = 100_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    smart_lift_ctrl_if.slave        bus
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    logic [FLOORS-1:0] sw_s1, sw_s2, sw_s2_d, rise_q;
    logic [FLOORS-1:0] pending, pending_n, req;
    logic [FLOORS-1:0] cur_oh, above_cur, below_cur;
    logic [FLOORS-1:0] nf_oh, above_nf, below_nf;
    state_t            state, state_n;
    logic              dir, dir_n;
    logic [FW-1:0]     floor_q, floor_n, nf;
    logic [TW-1:0]     tick_cnt, tick_n;
    logic [DW-1:0]     door_cnt, door_n;
    logic [3:0]        call_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            sw_s2_d  <= '0;
            rise_q   <= '0;
            pending  <= '0;
            state    <= IDLE;
            dir      <= UP;
            floor_q  <= '0;
            tick_cnt <= '0;
            door_cnt <= '0;
        end else begin
            sw_s1    <= bus.SW;
            sw_s2    <= sw_s1;
            sw_s2_d  <= sw_s2;
            rise_q   <= sw_s2 & ~sw_s2_d;
            pending  <= pending_n;
            state    <= state_n;
            dir      <= dir_n;
            floor_q  <= floor_n;
            tick_cnt <= tick_n;
            door_cnt <= door_n;
        end
    end

    // Floor masks relative to the current floor and to the floor the car
    // reaches at the end of the running travel tick.
    always_comb begin
        nf = (state == MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
        cur_oh    = '0;
        above_cur = '0;
        below_cur = '0;
        nf_oh     = '0;
        above_nf  = '0;
        below_nf  = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            cur_oh[i]    = (FW'(i) == floor_q);
            above_cur[i] = (FW'(i) >  floor_q);
            below_cur[i] = (FW'(i) <  floor_q);
            nf_oh[i]     = (FW'(i) == nf);
            above_nf[i]  = (FW'(i) >  nf);
            below_nf[i]  = (FW'(i) <  nf);
        end
    end

    always_comb begin
        state_n   = state;
        dir_n     = dir;
        floor_n   = floor_q;
        tick_n    = tick_cnt;
        door_n    = door_cnt;
        req       = pending | rise_q;
        pending_n = req;

        case (state)
            IDLE: begin
                pending_n = req & ~cur_oh;
                tick_n    = '0;
                door_n    = '0;
                if (|(rise_q & cur_oh)) begin
                    state_n = DOOR_OPEN;
                end else if (dir == UP && |(pending & above_cur)) begin
                    state_n = MOVE_UP;
                end else if (dir == DOWN && |(pending & below_cur)) begin
                    state_n = MOVE_DOWN;
                end else if (dir == UP && |(pending & below_cur)) begin
                    dir_n   = DOWN;
                    state_n = MOVE_DOWN;
                end else if (dir == DOWN && |(pending & above_cur)) begin
                    dir_n   = UP;
                    state_n = MOVE_UP;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (tick_cnt == TW'(FLOOR_TICKS - 1)) begin
                    tick_n  = '0;
                    floor_n = nf;
                    // A call edge for the arrival floor in this same cycle is
                    // served by this stop, so it is cleared rather than latched.
                    pending_n = req & ~nf_oh;
                    if (|(req & nf_oh)) begin
                        state_n = DOOR_OPEN;
                        door_n  = '0;
                    end else if (state == MOVE_UP) begin
                        if (|(pending_n & above_nf)) begin
                            state_n = MOVE_UP;
                        end else if (|(pending_n & below_nf)) begin
                            dir_n   = DOWN;
                            state_n = MOVE_DOWN;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        if (|(pending_n & below_nf)) begin
                            state_n = MOVE_DOWN;
                        end else if (|(pending_n & above_nf)) begin
                            dir_n   = UP;
                            state_n = MOVE_UP;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            DOOR_OPEN: begin
                pending_n = req & ~cur_oh;
                if (|(rise_q & cur_oh)) begin
                    door_n = '0;
                end else if (door_cnt == DW'(DOOR_TICKS - 1)) begin
                    door_n  = '0;
                    state_n = IDLE;
                end else begin
                    door_n = door_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        call_cnt = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            call_cnt = call_cnt + 4'(pending[i]);
        end
    end

    assign bus.floor = floor_q;
    assign bus.LED_R = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign bus.LED_G = (state == IDLE) || (state == DOOR_OPEN);

    seg7_decoder u_hx0 (
        .value (4'(floor_q)),
        .seg   (bus.HX0)
    );

    seg7_decoder u_hx1 (
        .value (call_cnt),
        .seg   (bus.HX1)
    );

endmodule

// File: tb/tb_smart_lift_ctrl.sv
// tb_smart_lift_ctrl
// Self-checking bench for smart_lift_ctrl (FLOORS=9, FLOOR_TICKS=4,
// DOOR_TICKS=3). Expected stop order comes from the SCAN rule applied to the
// set of calls; travel and dwell times from floor distance and tick counts.
module tb_smart_lift_ctrl;

    localparam int FLOORS      = 9;
    localparam int FLOOR_TICKS = 4;
    localparam int DOOR_TICKS  = 3;

    logic clock;
    logic reset;

    smart_lift_ctrl_if #(.FLOORS(FLOORS)) bus ();

    smart_lift_ctrl #(
        .FLOORS      (FLOORS),
        .FLOOR_TICKS (FLOOR_TICKS),
        .DOOR_TICKS  (DOOR_TICKS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [6:0] seg_tab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    int checks;
    int errors;
    int cur_floor;
    bit cur_dir;      // 1 = up
    int exp_stops[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SCAN order: calls ahead in the current direction nearest-first, then
    // the remaining calls behind nearest-first. Direction flips if any lie behind.
    task automatic plan_trip(input logic [8:0] calls);
        bit any_behind;
        any_behind = 1'b0;
        exp_stops.delete();
        if (cur_dir) begin
            for (int fl = cur_floor + 1; fl < FLOORS; fl++)
                if (calls[fl]) exp_stops.push_back(fl);
            for (int fl = cur_floor - 1; fl >= 0; fl--)
                if (calls[fl]) begin exp_stops.push_back(fl); any_behind = 1'b1; end
        end else begin
            for (int fl = cur_floor - 1; fl >= 0; fl--)
                if (calls[fl]) exp_stops.push_back(fl);
            for (int fl = cur_floor + 1; fl < FLOORS; fl++)
                if (calls[fl]) begin exp_stops.push_back(fl); any_behind = 1'b1; end
        end
        if (any_behind) cur_dir = ~cur_dir;
    endtask

    // Follows the car through every expected stop. first_seen: caller is at
    // a falling edge where LED_R is already high.
    task automatic run_legs(input bit first_seen);
        int prev, mv, gap, remaining, stop;
        bit moved;
        prev = cur_floor;
        remaining = exp_stops.size();
        for (int idx = 0; idx < exp_stops.size(); idx++) begin
            stop = exp_stops[idx];
            if (idx == 0) begin
                if (!first_seen) begin
                    gap = 0;
                    while (bus.LED_R !== 1'b1 && gap < 60) begin
                        @(negedge clock);
                        gap++;
                    end
                    if (bus.LED_R !== 1'b1) begin
                        checks++; errors++;
                        $display("FAIL start_timeout: LED_R=%b expected 1 within 60 cycles", bus.LED_R);
                        return;
                    end
                end
            end else begin
                gap = 0;
                while (bus.LED_R === 1'b0 && gap < 60) begin
                    gap++;
                    @(negedge clock);
                end
                checks++;
                if (gap !== DOOR_TICKS + 1) begin
                    errors++;
                    $display("FAIL door_gap stop %0d: got %0d cycles expected %0d", stop, gap, DOOR_TICKS + 1);
                end
            end
            mv = 0;
            while (bus.LED_R === 1'b1 && mv < 200) begin
                mv++;
                @(negedge clock);
            end
            remaining--;
            checks++;
            if (mv != ((stop > prev) ? stop - prev : prev - stop) * FLOOR_TICKS) begin
                errors++;
                $display("FAIL travel_time %0d->%0d: got %0d expected %0d", prev, stop, mv,
                         ((stop > prev) ? stop - prev : prev - stop) * FLOOR_TICKS);
            end
            checks++;
            if (bus.floor !== 4'(stop)) begin
                errors++;
                $display("FAIL arrive_floor: got %0d expected %0d", bus.floor, stop);
            end
            checks++;
            if (bus.HX0 !== seg_tab[stop]) begin
                errors++;
                $display("FAIL arrive_hx0: got %b expected %b", bus.HX0, seg_tab[stop]);
            end
            checks++;
            if (bus.HX1 !== seg_tab[remaining]) begin
                errors++;
                $display("FAIL arrive_hx1 at %0d: got %b expected %b", stop, bus.HX1, seg_tab[remaining]);
            end
            checks++;
            if (bus.LED_G !== 1'b1) begin
                errors++;
                $display("FAIL arrive_led_g at %0d: got %b expected 1", stop, bus.LED_G);
            end
            prev = stop;
        end
        cur_floor = prev;
        moved = 1'b0;
        repeat (DOOR_TICKS + 4) begin
            @(negedge clock);
            if (bus.LED_R !== 1'b0 || bus.LED_G !== 1'b1) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL settle_idle at %0d: LED_R=%b expected 0", cur_floor, bus.LED_R);
        end
    endtask

    task automatic press(input logic [8:0] mask);
        @(posedge clock); #1 bus.SW = mask;
        @(posedge clock); #1 bus.SW = '0;
    endtask

    task automatic trip(input logic [8:0] mask);
        int exp_cnt;
        logic [8:0] m;
        m = mask;
        m[cur_floor] = 1'b0;
        exp_cnt = $countones(m);
        plan_trip(mask);
        press(mask);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.HX1 !== seg_tab[exp_cnt]) begin
            errors++;
            $display("FAIL call_count: got %b expected %b", bus.HX1, seg_tab[exp_cnt]);
        end
        run_legs(1'b0);
    endtask

    task automatic test_reset();
        bit moved;
        reset = 1'b0;
        bus.SW = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.floor !== 4'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", bus.floor); end
        checks++;
        if (bus.LED_G !== 1'b1 || bus.LED_R !== 1'b0) begin
            errors++; $display("FAIL reset_leds: got G=%b R=%b expected G=1 R=0", bus.LED_G, bus.LED_R);
        end
        checks++;
        if (bus.HX0 !== 7'b0111111 || bus.HX1 !== 7'b0111111) begin
            errors++; $display("FAIL reset_digits: got %b/%b expected 0111111/0111111", bus.HX0, bus.HX1);
        end
        reset = 1'b1;
        moved = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.LED_R !== 1'b0 || bus.floor !== 4'd0 || bus.HX1 !== 7'b0111111) moved = 1'b1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL reset_idle: LED_R=%b floor=%0d expected 0/0", bus.LED_R, bus.floor); end
    endtask

    task automatic test_single_call();
        @(posedge clock); #1 bus.SW = 9'b000001000;
        @(posedge clock); #1 bus.SW = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.HX1 !== seg_tab[0]) begin errors++; $display("FAIL single_hx1_early: got %b expected %b", bus.HX1, seg_tab[0]); end
        @(posedge clock); @(negedge clock);
        checks++;
        if (bus.HX1 !== seg_tab[1] || bus.LED_R !== 1'b0) begin
            errors++; $display("FAIL single_visible: got HX1=%b R=%b expected %b/0", bus.HX1, bus.LED_R, seg_tab[1]);
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if (bus.LED_R !== 1'b1) begin errors++; $display("FAIL single_depart: got LED_R=%b expected 1", bus.LED_R); end
        plan_trip(9'b000001000);
        run_legs(1'b1);
    endtask

    task automatic test_scan_order();
        if (cur_floor != 4) trip(9'b000010000);
        trip(9'b101000100);
    endtask

    task automatic test_current_floor_call();
        int g, cnt;
        logic [8:0] fm, gm;
        g = (cur_floor == 5) ? 1 : 5;
        fm = '0; fm[cur_floor] = 1'b1;
        gm = '0; gm[g] = 1'b1;
        @(posedge clock); #1 bus.SW = fm | gm;
        @(posedge clock); #1 bus.SW = '0;
        @(posedge clock); #1 bus.SW = fm;
        @(posedge clock); #1 bus.SW = '0;
        cnt = 3;
        while (cnt < 40) begin
            @(negedge clock);
            if (cnt == 4) begin
                checks++;
                if (bus.HX1 !== seg_tab[1]) begin
                    errors++; $display("FAIL curfloor_not_latched: got %b expected %b", bus.HX1, seg_tab[1]);
                end
            end
            if (bus.LED_R === 1'b1) break;
            @(posedge clock);
            cnt++;
        end
        checks++;
        if (cnt != 3 + 3 + DOOR_TICKS + 1) begin
            errors++; $display("FAIL door_restart_latency: got %0d edges expected %0d", cnt, 3 + 3 + DOOR_TICKS + 1);
        end
        plan_trip(gm);
        run_legs(1'b1);
    endtask

    task automatic test_held_switch();
        bit moved;
        if (cur_floor == 5) trip(9'b000000001);
        @(posedge clock); #1 bus.SW = 9'b000100000;
        plan_trip(9'b000100000);
        run_legs(1'b0);
        moved = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (bus.LED_R !== 1'b0 || bus.HX1 !== seg_tab[0]) moved = 1'b1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL held_single_call: LED_R=%b HX1=%b expected 0/%b", bus.LED_R, bus.HX1, seg_tab[0]); end
        bus.SW = '0;
    endtask

    task automatic test_full_load();
        if (cur_floor != 0) trip(9'b000000001);
        trip(9'b111111111);
    endtask

    task automatic test_random_trips();
        logic [8:0] mask;
        for (int n = 0; n < 6; n++) begin
            mask = 9'($urandom_range(1, 511));
            mask[cur_floor] = 1'b0;
            if (mask == '0) mask[(cur_floor + 1) % FLOORS] = 1'b1;
            trip(mask);
        end
    endtask

    task automatic test_mid_travel_reset();
        int w;
        bit moved;
        if (cur_floor != 2) trip(9'b000000100);
        press(9'b010001000);
        w = 0;
        while (bus.LED_R !== 1'b1 && w < 40) begin
            @(negedge clock);
            w++;
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.LED_R !== 1'b1 || bus.floor !== 4'd2 || bus.HX1 !== seg_tab[2]) begin
            errors++; $display("FAIL pre_reset_state: got R=%b floor=%0d HX1=%b expected 1/2/%b",
                               bus.LED_R, bus.floor, bus.HX1, seg_tab[2]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.floor !== 4'd0 || bus.LED_G !== 1'b1 || bus.LED_R !== 1'b0) begin
            errors++; $display("FAIL async_reset_ctrl: got floor=%0d G=%b R=%b expected 0/1/0", bus.floor, bus.LED_G, bus.LED_R);
        end
        checks++;
        if (bus.HX0 !== seg_tab[0] || bus.HX1 !== seg_tab[0]) begin
            errors++; $display("FAIL async_reset_digits: got %b/%b expected %b/%b", bus.HX0, bus.HX1, seg_tab[0], seg_tab[0]);
        end
        @(negedge clock);
        reset = 1'b1;
        cur_floor = 0;
        cur_dir = 1'b1;
        moved = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.LED_R !== 1'b0 || bus.HX1 !== seg_tab[0]) moved = 1'b1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL calls_lost_after_reset: LED_R=%b HX1=%b expected 0/%b", bus.LED_R, bus.HX1, seg_tab[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur_floor = 0;
        cur_dir = 1'b1;
        reset = 1'b0;
        bus.SW = '0;
        test_reset();
        test_single_call();
        test_scan_order();
        test_current_floor_call();
        test_held_switch();
        test_full_load();
        test_random_trips();
        test_mid_travel_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
